// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: claims the 0x03xx_xxxx iomem window, decodes one of four
// peripheral slots and runs the request/ready handshake toward it. Unmapped
// slots and slots that never answer get a fixed error word so the CPU never hangs.
module iomem_bus_ctrl #(
    parameter logic [7:0]  REGION    = 8'h03,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [3:0]  SLOT_MASK = 4'b1111,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic          clk_bufg,
    input  logic          resetn,
    input  logic          iomem_valid,
    output logic          iomem_ready,
    input  logic [3:0]    iomem_wstrb,
    input  logic [31:0]   iomem_addr,
    input  logic [31:0]   iomem_wdata,
    output logic [31:0]   iomem_rdata,
    output logic [3:0]    s_valid,
    input  logic [3:0]    s_ready,
    output logic [3:0]    s_wstrb,
    output logic [19:0]   s_addr,
    output logic [31:0]   s_wdata,
    input  logic [127:0]  s_rdata,
    output logic          bus_err,
    output logic [7:0]    err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last timer value before the slot is declared dead.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_slot;
    logic [7:0]  r_timer;

    logic        w_hit;
    logic [1:0]  w_slot;
    logic        w_unmapped;
    logic        w_sel_ready;
    logic        w_timeout;

    assign w_hit       = iomem_valid && (iomem_addr[31:24] == REGION);
    assign w_slot      = iomem_addr[21:20];
    assign w_unmapped  = (iomem_addr[23:22] != 2'b00) || !SLOT_MASK[w_slot];
    assign w_sel_ready = s_ready[r_slot];
    assign w_timeout   = (r_timer == TIMEOUT_LAST);

    // State register; reset abandons any transaction in flight without a response.
    always_ff @(posedge clk_bufg) begin
        // NOTE: every clocked assignment is non-blocking so all registers update
        // from the same pre-edge values regardless of statement order.
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode and the per-state handshake outputs.
    always_comb begin
        // NOTE: every output gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_next      = r_state;
        s_valid     = 4'b0000;
        iomem_ready = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) w_next = w_unmapped ? ERR : REQ;
            end
            REQ: begin
                s_valid = 4'b0001 << r_slot;
                // A late answer on the final timer cycle still counts as success.
                if (w_sel_ready)    w_next = RESP;
                else if (w_timeout) w_next = ERR;
            end
            ERR: begin
                bus_err = 1'b1;
                w_next  = RESP;
            end
            RESP: begin
                iomem_ready = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: request latch, wait timer, response data and error counter.
    always_ff @(posedge clk_bufg) begin
        if (!resetn) begin
            r_slot      <= 2'd0;
            r_timer     <= 8'd0;
            s_wstrb     <= 4'd0;
            s_addr      <= 20'd0;
            s_wdata     <= 32'd0;
            iomem_rdata <= 32'd0;
            err_cnt     <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Slot-side request fields stay frozen until the next accepted hit.
                    if (w_hit) begin
                        r_slot  <= w_slot;
                        s_wstrb <= iomem_wstrb;
                        s_addr  <= iomem_addr[19:0];
                        s_wdata <= iomem_wdata;
                        r_timer <= 8'd0;
                    end
                end
                REQ: begin
                    r_timer <= r_timer + 8'd1;
                    if (w_sel_ready) iomem_rdata <= s_rdata[{r_slot, 5'd0} +: 32];
                end
                ERR: begin
                    iomem_rdata <= ERR_DATA;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// tb_iomem_bus_ctrl: acts as both CPU and slots, predicts each transaction's
// latency, data and error outcome from the controller's rules, and compares.
module tb_iomem_bus_ctrl;

    localparam int          TO    = 8;
    localparam logic [3:0]  MASK  = 4'b1111;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic          clk_bufg = 1'b0;
    logic          resetn;
    logic          iomem_valid;
    logic          iomem_ready;
    logic [3:0]    iomem_wstrb;
    logic [31:0]   iomem_addr;
    logic [31:0]   iomem_wdata;
    logic [31:0]   iomem_rdata;
    logic [3:0]    s_valid;
    logic [3:0]    s_ready;
    logic [3:0]    s_wstrb;
    logic [19:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [127:0]  s_rdata;
    logic          bus_err;
    logic [7:0]    err_cnt;

    int n_checks  = 0;
    int n_errors  = 0;
    int m_err_cnt = 0;

    iomem_bus_ctrl #(
        .REGION    (8'h03),
        .TIMEOUT   (TO),
        .SLOT_MASK (MASK),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk_bufg    (clk_bufg),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .bus_err     (bus_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk_bufg = ~clk_bufg;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bufg);
        @(negedge clk_bufg);
    endtask

    // One CPU transaction, entered and left at a negedge. ready_at is the cycle
    // (counted from the CPU request cycle 0) in which the selected slot answers;
    // 0 means never. hold keeps iomem_valid asserted past completion.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int ready_at,
                           input logic [31:0] slot_data, input bit hold);
        int           slot;
        bit           unmapped;
        bit           exp_err;
        int           exp_lat;
        int           last_req;
        int           lat;
        int           berr_seen;
        logic [31:0]  exp_rdata;
        logic [3:0]   exp_sv;
        logic [3:0]   noise;
        logic [127:0] rd;

        slot     = int'(addr[21:20]);
        unmapped = (addr[23:22] != 2'b00) || !MASK[slot];
        if (unmapped) begin
            exp_lat = 2; exp_err = 1'b1; last_req = 0;
        end else if (ready_at >= 1 && ready_at <= TO) begin
            exp_lat = ready_at + 1; exp_err = 1'b0; last_req = ready_at;
        end else begin
            exp_lat = TO + 2; exp_err = 1'b1; last_req = TO;
        end
        exp_rdata = exp_err ? ERRD : slot_data;

        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        s_ready     = 4'b0000;
        s_rdata     = {$urandom, $urandom, $urandom, $urandom};

        lat = 0;
        berr_seen = 0;
        for (int c = 1; c <= TO + 6 && lat == 0; c++) begin
            tick();
            if (!hold) begin
                iomem_valid = 1'b0;
                iomem_addr  = $urandom;
                iomem_wdata = $urandom;
                iomem_wstrb = 4'($urandom);
            end
            exp_sv = (!unmapped && c <= last_req) ? (4'b0001 << slot) : 4'b0000;
            check("s_valid", 32'(s_valid), 32'(exp_sv));
            check("s_addr",  32'(s_addr),  32'(addr[19:0]));
            check("s_wdata", s_wdata, wdata);
            check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
            if (bus_err) berr_seen++;
            if (iomem_ready) begin
                lat = c;
                check("rdata", iomem_rdata, exp_rdata);
            end
            rd    = {$urandom, $urandom, $urandom, $urandom};
            noise = 4'($urandom);
            if (c == ready_at) begin
                rd[slot*32 +: 32] = slot_data;
                noise[slot] = 1'b1;
            end else begin
                noise[slot] = 1'b0;
            end
            s_ready = noise;
            s_rdata = rd;
        end
        check("latency", lat, exp_lat);
        if (exp_err && m_err_cnt < 255) m_err_cnt++;
        check("bus_err_pulses", berr_seen, 32'(exp_err));
        check("err_cnt", 32'(err_cnt), m_err_cnt);

        tick();
        s_ready = 4'b0000;
        check("ready_width", 32'(iomem_ready), 32'd0);
        check("s_valid_idle", 32'(s_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  hi;
        logic [1:0]  sl;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        s_ready     = 4'd0;
        s_rdata     = 128'd0;
        repeat (3) tick();

        // Reset state
        check("rst_ready",   32'(iomem_ready), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rdata",   iomem_rdata, 32'd0);
        check("rst_s_addr",  32'(s_addr), 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        resetn = 1'b1;
        tick();

        // Directed: slot1 write, slot0 same-cycle read, unmapped, timeout, last-cycle answer
        run_txn(32'h0310_0004, 4'hF, 32'hA5A5_A5A5, 3, $urandom, 1'b0);
        run_txn(32'h0300_0000, 4'h0, 32'h0,         1, 32'h1234_5678, 1'b0);
        run_txn(32'h0340_0000, 4'h0, 32'h0,         0, 32'h0, 1'b0);
        run_txn(32'h0320_0010, 4'h0, 32'h0,         0, 32'h1111_2222, 1'b0);
        run_txn(32'h0320_0010, 4'h0, 32'h0,         TO, 32'hCAFE_F00D, 1'b0);
        run_txn(32'h0380_0000, 4'h3, 32'h5555_0000, 2, 32'h0, 1'b0);

        // Outside the region: no response and no slot request
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nohit_ready",   32'(iomem_ready), 32'd0);
            check("nohit_s_valid", 32'(s_valid), 32'd0);
        end
        iomem_valid = 1'b0;
        tick();

        // Back-to-back to slot3 with iomem_valid held across the response
        run_txn(32'h0330_0008, 4'h0, 32'h0,         2, 32'h3333_0001, 1'b1);
        run_txn(32'h0330_000C, 4'hF, 32'h9876_5432, 1, 32'h3333_0002, 1'b1);
        iomem_valid = 1'b0;
        tick();

        // Randomized mix of slots, mapping, answer timing and held valid
        for (int n = 0; n < 150; n++) begin
            sl = 2'($urandom);
            hi = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a  = {8'h03, hi, sl, 20'($urandom)};
            run_txn(a, 4'($urandom), $urandom, int'($urandom_range(0, TO + 1)),
                    $urandom, ($urandom_range(0, 3) == 0));
        end
        iomem_valid = 1'b0;
        tick();

        // Reset while a slot request is outstanding
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0310_0000;
        iomem_wstrb = 4'h0;
        tick();
        iomem_valid = 1'b0;
        check("pre_rst_s_valid", 32'(s_valid), 32'b0010);
        resetn = 1'b0;
        tick();
        m_err_cnt = 0;
        check("mid_rst_s_valid", 32'(s_valid), 32'd0);
        check("mid_rst_ready",   32'(iomem_ready), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_s_addr",  32'(s_addr), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_ready = 4'b1111;
            tick();
            check("post_rst_ready",   32'(iomem_ready), 32'd0);
            check("post_rst_s_valid", 32'(s_valid), 32'd0);
        end
        s_ready = 4'b0000;
        run_txn(32'h0310_0020, 4'h1, 32'h0000_00AB, 2, 32'h0BAD_F00D, 1'b0);

        // Error counter saturation
        for (int n = 0; n < 260; n++) begin
            run_txn({8'h03, 2'($urandom_range(1, 3)), 2'($urandom), 20'($urandom)},
                    4'h0, $urandom, 0, 32'h0, 1'b0);
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
